gain_cfg_axil_master: RTL



---
 rtl/gain_cfg_axil_master.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/gain_cfg_axil_master.sv
// AXI-Lite write initiator that programs GAIN_L, GAIN_R, then CTRL of the gain block.
// Define GAIN_CFG_READBACK_EN to read all three registers back and verify them.
`timescale 1ns/1ps
module gain_cfg_axil_master #(
   parameter int ADDR_WIDTH     = 4,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int GAIN_WIDTH     = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_enable,
   input  logic [GAIN_WIDTH-1:0] cmd_gain_l,
   input  logic [GAIN_WIDTH-1:0] cmd_gain_r,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [31:0]           m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR_ADDR = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD_ADDR = 3'd3;
   localparam logic [2:0] S_RD_DATA = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;
   localparam logic [2:0] S_ERR     = 3'd6;

   localparam int TW = $clog2(TIMEOUT_CYCLES);

   logic [2:0]            state;
   logic [1:0]            idx;
   logic [GAIN_WIDTH-1:0] gl_q;
   logic [GAIN_WIDTH-1:0] gr_q;
   logic                  en_q;
   logic [TW-1:0]         tcnt;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  tmo;

   // Register sequence index: 0 = GAIN_L, 1 = GAIN_R, 2 = CTRL
   function automatic logic [ADDR_WIDTH-1:0] reg_addr(input logic [1:0] i);
      case (i)
         2'd0:    reg_addr = ADDR_WIDTH'(4);
         2'd1:    reg_addr = ADDR_WIDTH'(8);
         default: reg_addr = '0;
      endcase
   endfunction

   function automatic logic [31:0] reg_data(
      input logic [1:0]            i,
      input logic [GAIN_WIDTH-1:0] gl,
      input logic [GAIN_WIDTH-1:0] gr,
      input logic                  en
   );
      case (i)
         2'd0:    reg_data = 32'(gl);
         2'd1:    reg_data = 32'(gr);
         default: reg_data = {31'b0, en};
      endcase
   endfunction

   assign aw_hs = m_axi_awvalid && m_axi_awready;
   assign w_hs  = m_axi_wvalid && m_axi_wready;
   assign tmo   = (tcnt == TW'(TIMEOUT_CYCLES - 1));

`ifdef GAIN_CFG_READBACK_EN
   logic [ADDR_WIDTH-1:0] ar_addr;
   logic                  ar_valid;
`endif

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state         <= S_IDLE;
         idx           <= '0;
         gl_q          <= '0;
         gr_q          <= '0;
         en_q          <= 1'b0;
         tcnt          <= '0;
         err_code      <= 2'b00;
         m_axi_awaddr  <= '0;
         m_axi_wdata   <= '0;
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
`ifdef GAIN_CFG_READBACK_EN
         ar_addr       <= '0;
         ar_valid      <= 1'b0;
`endif
      end else begin
         tcnt <= tcnt + TW'(1);
         case (state)
            S_IDLE: begin
               tcnt <= '0;
               if (cmd_valid) begin
                  gl_q          <= cmd_gain_l;
                  gr_q          <= cmd_gain_r;
                  en_q          <= cmd_enable;
                  err_code      <= 2'b00;
                  idx           <= 2'd0;
                  m_axi_awaddr  <= reg_addr(2'd0);
                  m_axi_wdata   <= 32'(cmd_gain_l);
                  m_axi_awvalid <= 1'b1;
                  m_axi_wvalid  <= 1'b1;
                  state         <= S_WR_ADDR;
               end
            end
            S_WR_ADDR: begin
               if (aw_hs) m_axi_awvalid <= 1'b0;
               if (w_hs) m_axi_wvalid <= 1'b0;
               // AW and W may complete in either order or together
               if ((!m_axi_awvalid || m_axi_awready) &&
                   (!m_axi_wvalid || m_axi_wready)) begin
                  tcnt  <= '0;
                  state <= S_WR_RESP;
               end else if (aw_hs || w_hs) begin
                  tcnt <= '0;
               end else if (tmo) begin
                  tcnt          <= '0;
                  m_axi_awvalid <= 1'b0;
                  m_axi_wvalid  <= 1'b0;
                  err_code      <= 2'b10;
                  state         <= S_ERR;
               end
            end
            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  tcnt <= '0;
                  if (m_axi_bresp != 2'b00) begin
                     err_code <= 2'b01;
                     state    <= S_ERR;
                  end else if (idx == 2'd2) begin
`ifdef GAIN_CFG_READBACK_EN
                     idx      <= 2'd0;
                     ar_addr  <= reg_addr(2'd0);
                     ar_valid <= 1'b1;
                     state    <= S_RD_ADDR;
`else
                     state    <= S_DONE;
`endif
                  end else begin
                     idx           <= idx + 2'd1;
                     m_axi_awaddr  <= reg_addr(idx + 2'd1);
                     m_axi_wdata   <= reg_data(idx + 2'd1, gl_q, gr_q, en_q);
                     m_axi_awvalid <= 1'b1;
                     m_axi_wvalid  <= 1'b1;
                     state         <= S_WR_ADDR;
                  end
               end else if (tmo) begin
                  tcnt     <= '0;
                  err_code <= 2'b10;
                  state    <= S_ERR;
               end
            end
`ifdef GAIN_CFG_READBACK_EN
            S_RD_ADDR: begin
               if (m_axi_arready) begin
                  tcnt     <= '0;
                  ar_valid <= 1'b0;
                  state    <= S_RD_DATA;
               end else if (tmo) begin
                  tcnt     <= '0;
                  ar_valid <= 1'b0;
                  err_code <= 2'b10;
                  state    <= S_ERR;
               end
            end
            S_RD_DATA: begin
               if (m_axi_rvalid) begin
                  tcnt <= '0;
                  if (m_axi_rresp != 2'b00) begin
                     err_code <= 2'b01;
                     state    <= S_ERR;
                  end else if (m_axi_rdata != reg_data(idx, gl_q, gr_q, en_q)) begin
                     err_code <= 2'b11;
                     state    <= S_ERR;
                  end else if (idx == 2'd2) begin
                     state <= S_DONE;
                  end else begin
                     idx      <= idx + 2'd1;
                     ar_addr  <= reg_addr(idx + 2'd1);
                     ar_valid <= 1'b1;
                     state    <= S_RD_ADDR;
                  end
               end else if (tmo) begin
                  tcnt     <= '0;
                  err_code <= 2'b10;
                  state    <= S_ERR;
               end
            end
`endif
            S_DONE, S_ERR: begin
               tcnt  <= '0;
               state <= S_IDLE;
            end
            default: begin
               tcnt  <= '0;
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready    = (state == S_IDLE);
   assign busy         = (state == S_WR_ADDR) || (state == S_WR_RESP) ||
                         (state == S_RD_ADDR) || (state == S_RD_DATA);
   assign done         = (state == S_DONE);
   assign err          = (state == S_ERR);
   assign m_axi_bready = (state == S_WR_RESP);
   assign m_axi_wstrb  = 4'hF;

`ifdef GAIN_CFG_READBACK_EN
   assign m_axi_araddr  = ar_addr;
   assign m_axi_arvalid = ar_valid;
   assign m_axi_rready  = (state == S_RD_DATA);
`else
   assign m_axi_araddr  = '0;
   assign m_axi_arvalid = 1'b0;
   assign m_axi_rready  = 1'b0;
   logic unused_rd;
   assign unused_rd = ^{m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid};
`endif

endmodule
